lc4_div_sched: RTL and testbench
================================

// Module: lc4_div_sched
// PURPOSE
//  Multi-cycle unsigned divide/mod unit shared by the two pipes (A, B) of the superscalar LC4 core.
//  Replaces the combinational divider on the DIV/MOD path, which is too slow for the pipeline.
//  Round-robin arbitrates the two requesters, then runs an iterative restoring divide.
//  Returns quotient and remainder through a valid/ready result port tagged with the winning pipe.
// PARAMETERS
//  DATA_W    16  operand/result width
//  BITS_PER  1   quotient bits resolved per cycle; must divide DATA_W; N = DATA_W/BITS_PER
// PORTS
//  clk          in   1       core clock
//  rst_n        in   1       asynchronous reset, active low
//  i_flush      in   1       synchronous abort of the current operation (branch mispredict)
//  i_valid_a    in   1       pipe A request
//  i_dividend_a in   DATA_W  pipe A dividend (rs)
//  i_divisor_a  in   DATA_W  pipe A divisor (rt)
//  o_ready_a    out  1       pipe A request accepted this cycle when valid&ready
//  i_valid_b    in   1       pipe B request
//  i_dividend_b in   DATA_W  pipe B dividend
//  i_divisor_b  in   DATA_W  pipe B divisor
//  o_ready_b    out  1       pipe B request accepted this cycle when valid&ready
//  o_valid      out  1       result available
//  i_res_ready  in   1       consumer takes the result this cycle
//  o_id         out  1       0 = result belongs to A, 1 = result belongs to B
//  o_quotient   out  DATA_W  unsigned quotient
//  o_remainder  out  DATA_W  unsigned remainder
//  o_busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; o_valid=0; o_id=0; o_quotient=0; o_remainder=0; o_busy=0
//   - rr priority = A; o_ready_a = o_ready_b = 0 while rst_n is low
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE:
//   - only state accepting requests
//   - grant = the side with valid; if both valid, the priority side
//   - o_ready_x = (state==IDLE) & !i_flush & grant==x; combinational; at most one high
//   - on accept: latch operands and id, count=0, priority flips to the non-granted side
//   - with one requester valid, priority flips to the other side
//   - divisor==0: go straight to DONE with q=0, r=0; o_valid rises the edge after accept
//   - else go to BUSY
//  BUSY:
//   - each edge performs BITS_PER restoring steps, MSB first:
//     rem = {rem,dvd_msb}; if rem>=divisor {rem-=divisor; qbit=1}
//   - count += BITS_PER; the edge on which count reaches DATA_W moves to DONE
//   - accept at edge k => o_valid high after edge k+N (default 16)
//   - partial rem is DATA_W+1 bits internally; no overflow
//  DONE:
//   - o_valid=1; o_id, o_quotient, o_remainder held stable until i_res_ready
//   - valid&ready edge -> IDLE; a new request is accepted no earlier than the next cycle
//  i_flush:
//   - in BUSY or DONE -> IDLE at next edge; result discarded, no o_valid pulse
//   - in IDLE, no accept that cycle
//   - priority is unchanged by flush
//  Flush wins over i_res_ready in the same DONE cycle; the result is dropped.
//  Operand inputs are ignored outside the accept cycle; changing them mid-op has no effect.
//  Outputs o_quotient and o_remainder keep the last result after returning to IDLE.
// TESTING
//  1. A: 100/7, B idle -> o_ready_a=1; o_valid after 16 edges: o_id=0, q=14, r=2.
//  2. A: 0xFFFF/1 -> q=0xFFFF, r=0. A: 5/0x8000 -> q=0, r=5.
//  3. A,B valid at same cycle after reset, res_ready=1:
//     - A granted first, result A: 9/2 -> q=4, r=1
//     - B granted on the next IDLE cycle, result B: 30/4 -> q=7, r=2
//     - then both again -> B, then A
//  4. A: 1234/0 -> o_valid the edge after accept, q=0, r=0; o_busy high for exactly 1 cycle.
//  5. Hold i_res_ready=0 for 5 cycles in DONE:
//     - o_valid stays 1, outputs constant, o_ready_a/b=0
//     - then 1 for one cycle -> IDLE, ready high the next cycle
//  6. Flush at the 8th BUSY cycle -> no o_valid, IDLE next edge.
//     Separately, drop rst_n mid-BUSY -> all outputs reset immediately (async).

Source files
------------

// File: rtl/lc4_div_sched.sv
// Shared multi-cycle unsigned DIV/MOD unit for the two LC4 pipes.
// Round-robin arbitration between pipes A and B feeds an iterative restoring divider.
module lc4_div_sched #(
  parameter int DATA_W   = 16,
  parameter int BITS_PER = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_valid_a,
  input  logic [DATA_W-1:0] i_dividend_a,
  input  logic [DATA_W-1:0] i_divisor_a,
  output logic              o_ready_a,
  input  logic              i_valid_b,
  input  logic [DATA_W-1:0] i_dividend_b,
  input  logic [DATA_W-1:0] i_divisor_b,
  output logic              o_ready_b,
  output logic              o_valid,
  input  logic              i_res_ready,
  output logic              o_id,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              prio;
  logic              grant;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_dvd, sel_dvs;
  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              last_step;
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] dvd_step;

  // prio: 0 favours A, 1 favours B; it only matters when both pipes request
  always_comb begin
    grant      = (i_valid_a & i_valid_b) ? prio : i_valid_b;
    can_accept = rst_n & (state == IDLE) & ~i_flush;
    o_ready_a  = can_accept & i_valid_a & ~grant;
    o_ready_b  = can_accept & i_valid_b & grant;
    accept     = o_ready_a | o_ready_b;
    sel_dvd    = grant ? i_dividend_b : i_dividend_a;
    sel_dvs    = grant ? i_divisor_b  : i_divisor_a;
    o_valid    = (state == DONE);
    o_busy     = (state != IDLE);
  end

  // Quotient bits shift into the vacated low end of the dividend register
  always_comb begin
    part     = {1'b0, rem_q};
    dvd_step = dvd_q;
    for (int i = 0; i < BITS_PER; i++) begin
      part     = {part[DATA_W-1:0], dvd_step[DATA_W-1]};
      dvd_step = {dvd_step[DATA_W-2:0], 1'b0};
      if (part >= {1'b0, dvs_q}) begin
        part        = part - {1'b0, dvs_q};
        dvd_step[0] = 1'b1;
      end
    end
    count_nxt = count + CNT_W'(BITS_PER);
    last_step = (count_nxt == CNT_W'(DATA_W));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (sel_dvs == '0) ? DONE : BUSY;
      BUSY: begin
        if (i_flush)        state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: if (i_flush || i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result registers change only at completion, so they hold through DONE and after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio        <= 1'b0;
      o_id        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count       <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (accept) begin
      prio  <= ~grant;
      o_id  <= grant;
      dvd_q <= sel_dvd;
      dvs_q <= sel_dvs;
      rem_q <= '0;
      count <= '0;
      if (sel_dvs == '0) begin
        o_quotient  <= '0;
        o_remainder <= '0;
      end
    end else if (state == BUSY && !i_flush) begin
      dvd_q <= dvd_step;
      rem_q <= part[DATA_W-1:0];
      count <= count_nxt;
      if (last_step) begin
        o_quotient  <= dvd_step;
        o_remainder <= part[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lc4_div_sched.sv
// Self-checking bench for lc4_div_sched: directed arbitration/latency/flush/reset cases
// plus random operations, with results scoreboarded against a reference divide.
module tb_lc4_div_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid_a = 1'b0, i_valid_b = 1'b0;
  logic [15:0] i_dividend_a = '0, i_divisor_a = '0;
  logic [15:0] i_dividend_b = '0, i_divisor_b = '0;
  logic        i_res_ready = 1'b1;
  logic        o_ready_a, o_ready_b, o_valid, o_id, o_busy;
  logic [15:0] o_quotient, o_remainder;

  typedef struct packed {
    logic        id;
    logic [15:0] q;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  lc4_div_sched #(.DATA_W(16), .BITS_PER(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_valid_a(i_valid_a), .i_dividend_a(i_dividend_a), .i_divisor_a(i_divisor_a),
    .o_ready_a(o_ready_a),
    .i_valid_b(i_valid_b), .i_dividend_b(i_dividend_b), .i_divisor_b(i_divisor_b),
    .o_ready_b(o_ready_b),
    .o_valid(o_valid), .i_res_ready(i_res_ready), .o_id(o_id),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [15:0] dvd, input logic [15:0] dvs);
    exp_t e;
    e.id = id;
    e.q  = (dvs == 16'd0) ? 16'd0 : dvd / dvs;
    e.r  = (dvs == 16'd0) ? 16'd0 : dvd % dvs;
    return e;
  endfunction

  task automatic applyStimulus(input logic va, input logic [15:0] da, input logic [15:0] sa,
                               input logic vb, input logic [15:0] db, input logic [15:0] sb_in);
    i_valid_a = va; i_dividend_a = da; i_divisor_a = sa;
    i_valid_b = vb; i_dividend_b = db; i_divisor_b = sb_in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the chosen side and waits for the unit to drain
  task automatic run_op(input logic side, input logic [15:0] dvd, input logic [15:0] dvs);
    int n;
    if (side) applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, dvd, dvs);
    else      applyStimulus(1'b1, dvd, dvs, 1'b0, 16'd0, 16'd0);
    #1;
    n = 0;
    while (!(side ? o_ready_b : o_ready_a) && n < 40) begin step(); n++; end
    if (n >= 40) checkOutput("accept_timeout", 32'd0, 32'd1);
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    n = 0;
    while (o_busy && n < 60) begin step(); n++; end
    if (n >= 60) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: push on accept, drop on flush, pop and compare on result transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (i_valid_a && o_ready_a) sb.push_back(model(1'b0, i_dividend_a, i_divisor_a));
      if (i_valid_b && o_ready_b) sb.push_back(model(1'b1, i_dividend_b, i_divisor_b));
      if (i_flush && o_busy) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (o_valid && i_res_ready) begin
        if (sb.size() == 0) checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          checkOutput("sb_id", {31'd0, o_id}, {31'd0, e.id});
          checkOutput("sb_quotient", {16'd0, o_quotient}, {16'd0, e.q});
          checkOutput("sb_remainder", {16'd0, o_remainder}, {16'd0, e.r});
        end
      end
    end
  end

  always @(negedge rst_n) sb.delete();

  initial begin
    int n;
    int bad;
    logic side;

    // Reset state, with a request pending to show ready is held low
    applyStimulus(1'b1, 16'd3, 16'd1, 1'b1, 16'd3, 16'd1);
    #12;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("rst_id", {31'd0, o_id}, 32'd0);
    checkOutput("rst_quotient", {16'd0, o_quotient}, 32'd0);
    checkOutput("rst_remainder", {16'd0, o_remainder}, 32'd0);
    checkOutput("rst_ready_a", {31'd0, o_ready_a}, 32'd0);
    checkOutput("rst_ready_b", {31'd0, o_ready_b}, 32'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 100/7 from A: ready immediately, result 16 edges after accept
    applyStimulus(1'b1, 16'd100, 16'd7, 1'b0, 16'd0, 16'd0);
    #1;
    checkOutput("t1_ready_a", {31'd0, o_ready_a}, 32'd1);
    checkOutput("t1_ready_b", {31'd0, o_ready_b}, 32'd0);
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    n = 0;
    while (!o_valid && n < 40) begin step(); n++; end
    checkOutput("t1_latency", n, 32'd16);
    checkOutput("t1_quotient", {16'd0, o_quotient}, 32'd14);
    checkOutput("t1_remainder", {16'd0, o_remainder}, 32'd2);
    step();

    // Boundary operands
    run_op(1'b0, 16'hFFFF, 16'd1);
    run_op(1'b0, 16'd5, 16'h8000);
    run_op(1'b1, 16'hFFFF, 16'hFFFF);

    // Both pipes requesting continuously from reset: grants alternate A, B, A, B
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    applyStimulus(1'b1, 16'd9, 16'd2, 1'b1, 16'd30, 16'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(o_ready_a || o_ready_b) && n < 40) begin step(); n++; end
      if (n >= 40) checkOutput("t3_grant_timeout", 32'd0, 32'd1);
      checkOutput("t3_ready_a", {31'd0, o_ready_a}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("t3_ready_b", {31'd0, o_ready_b}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    n = 0;
    while (o_busy && n < 60) begin step(); n++; end

    // Divide by zero completes the edge after accept, busy for exactly one cycle
    applyStimulus(1'b1, 16'd1234, 16'd0, 1'b0, 16'd0, 16'd0);
    #1;
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    checkOutput("t4_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("t4_busy_first", {31'd0, o_busy}, 32'd1);
    checkOutput("t4_quotient", {16'd0, o_quotient}, 32'd0);
    step();
    checkOutput("t4_busy_after", {31'd0, o_busy}, 32'd0);

    // Consumer back-pressure: DONE holds while a new request waits
    i_res_ready = 1'b0;
    applyStimulus(1'b1, 16'd50, 16'd3, 1'b0, 16'd0, 16'd0);
    #1;
    step();
    applyStimulus(1'b1, 16'd7, 16'd7, 1'b0, 16'd0, 16'd0);
    n = 0;
    while (!o_valid && n < 40) begin step(); n++; end
    for (int k = 0; k < 5; k++) begin
      checkOutput("t5_hold_valid", {31'd0, o_valid}, 32'd1);
      checkOutput("t5_hold_quotient", {16'd0, o_quotient}, 32'd16);
      checkOutput("t5_hold_remainder", {16'd0, o_remainder}, 32'd2);
      checkOutput("t5_hold_ready_a", {31'd0, o_ready_a}, 32'd0);
      step();
    end
    i_res_ready = 1'b1;
    step();
    checkOutput("t5_ready_after", {31'd0, o_ready_a}, 32'd1);
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    n = 0;
    while (o_busy && n < 60) begin step(); n++; end

    // Flush on the 8th busy cycle: no result, outputs keep the 7/7 result
    applyStimulus(1'b1, 16'd100, 16'd7, 1'b0, 16'd0, 16'd0);
    #1;
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    for (int k = 0; k < 7; k++) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    checkOutput("t6_flush_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("t6_flush_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("t6_flush_quotient", {16'd0, o_quotient}, 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) bad++;
      step();
    end
    checkOutput("t6_no_valid_pulse", bad, 32'd0);

    // Asynchronous reset in the middle of an operation
    applyStimulus(1'b1, 16'd200, 16'd3, 1'b0, 16'd0, 16'd0);
    #1;
    step();
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_arst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("t6_arst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("t6_arst_quotient", {16'd0, o_quotient}, 32'd0);
    checkOutput("t6_arst_ready_a", {31'd0, o_ready_a}, 32'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Random operations on either pipe, divisor occasionally zero
    for (int k = 0; k < 10; k++) begin
      side = 1'($urandom_range(0, 1));
      run_op(side, 16'($urandom), 16'($urandom_range(0, 300)));
    end

    step();
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
